ps2_note_decoder: RTL and testbench

Converts the PS/2 scan-code byte stream into note-on/note-off events for the synth voice logic. It sits directly downstream of the keyboard receiver and oneshot pulser, and consumes one byte per `scan_valid` pulse. It tracks make/break/extended prefixes, suppresses typematic repeats, and manages an octave register. Events are queued in a small FIFO with a valid/ready handshake toward the voice allocator.

---
 rtl/ps2_note_decoder_pkg.sv | 79 +++++++
 rtl/ps2_note_decoder_if.sv | 10 +
 rtl/ps2_note_decoder_fifo.sv | 58 +++++
 rtl/ps2_note_decoder.sv | 113 +++++++++++
 tb/tb_ps2_note_decoder.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ps2_note_decoder_pkg.sv
// Shared types for the PS/2 note decoder: scan-code constants, event layout,
// prefix FSM states, the key map and the note-number arithmetic.
package ps2_pkg;

   localparam logic [7:0] SC_BREAK    = 8'hF0;
   localparam logic [7:0] SC_EXT      = 8'hE0;
   localparam logic [7:0] SC_OCT_DOWN = 8'h1A;
   localparam logic [7:0] SC_OCT_UP   = 8'h22;
   localparam logic [7:0] SC_K0  = 8'h1C;
   localparam logic [7:0] SC_K1  = 8'h1D;
   localparam logic [7:0] SC_K2  = 8'h1B;
   localparam logic [7:0] SC_K3  = 8'h24;
   localparam logic [7:0] SC_K4  = 8'h23;
   localparam logic [7:0] SC_K5  = 8'h2B;
   localparam logic [7:0] SC_K6  = 8'h2C;
   localparam logic [7:0] SC_K7  = 8'h34;
   localparam logic [7:0] SC_K8  = 8'h35;
   localparam logic [7:0] SC_K9  = 8'h33;
   localparam logic [7:0] SC_K10 = 8'h3C;
   localparam logic [7:0] SC_K11 = 8'h3B;
   localparam logic [7:0] SC_K12 = 8'h42;

   localparam int NUM_KEYS = 13;
   // Octave keys share the key-index space, just past the note keys
   localparam logic [3:0] KEY_OCT_DOWN = 4'd13;
   localparam logic [3:0] KEY_OCT_UP   = 4'd14;

   typedef struct packed {
      logic       on;
      logic [6:0] note;
   } note_event_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_BREAK,
      ST_EXT,
      ST_EXT_BREAK
   } prefix_state_t;

   typedef struct packed {
      logic       hit;
      logic [3:0] key;
   } key_map_t;

   function automatic key_map_t map_code(input logic [7:0] code);
      key_map_t m;
      m.hit = 1'b1;
      case (code)
         SC_K0:       m.key = 4'd0;
         SC_K1:       m.key = 4'd1;
         SC_K2:       m.key = 4'd2;
         SC_K3:       m.key = 4'd3;
         SC_K4:       m.key = 4'd4;
         SC_K5:       m.key = 4'd5;
         SC_K6:       m.key = 4'd6;
         SC_K7:       m.key = 4'd7;
         SC_K8:       m.key = 4'd8;
         SC_K9:       m.key = 4'd9;
         SC_K10:      m.key = 4'd10;
         SC_K11:      m.key = 4'd11;
         SC_K12:      m.key = 4'd12;
         SC_OCT_DOWN: m.key = KEY_OCT_DOWN;
         SC_OCT_UP:   m.key = KEY_OCT_UP;
         default: begin
            m.hit = 1'b0;
            m.key = 4'd0;
         end
      endcase
      return m;
   endfunction

   // 12*oct + key via shifts; only octave 7 / key 12 exceeds 95 and is clamped
   function automatic logic [6:0] note_number(input logic [2:0] oct, input logic [3:0] key);
      logic [6:0] n;
      n = {1'b0, oct, 3'b000} + {2'b00, oct, 2'b00} + {3'b000, key};
      return (n > 7'd95) ? 7'd95 : n;
   endfunction

endpackage

// File: rtl/ps2_note_decoder_if.sv
// Valid/ready event channel from the note decoder to the voice allocator.
interface ps2_note_decoder_if;
   logic       ev_valid;
   logic       ev_on;
   logic [6:0] ev_note;
   logic       ev_ready;

   modport master (output ev_valid, ev_on, ev_note, input ev_ready);
   modport slave  (input ev_valid, ev_on, ev_note, output ev_ready);
endinterface

// File: rtl/ps2_note_decoder_fifo.sv
// Small synchronous event FIFO; the head entry is presented combinationally
// and a push while full is only accepted when a pop frees a slot that cycle.
module event_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             overflow
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic             overflow_reg;
   logic             full;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count_reg == '0);
   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr_reg] <= push_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (push && !do_push) overflow_reg <= 1'b1;
      end
   end

   assign head_data = empty ? '0 : mem[rd_ptr_reg];
   assign overflow  = overflow_reg;
endmodule

// File: rtl/ps2_note_decoder.sv
// PS/2 scan-code stream to note-on/note-off events: prefix tracking, typematic
// suppression, octave register and per-key latched octave for releases.
module ps2_note_decoder
   import ps2_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int OCT_RESET  = 4
) (
   input  logic                clock50,
   input  logic                reset_n,
   input  logic [7:0]          scan_code,
   input  logic                scan_valid,
   ps2_note_decoder_if.master  ev,
   output logic [12:0]         held,
   output logic [2:0]          octave,
   output logic                overflow
);
   prefix_state_t state_reg;
   logic [12:0]   held_reg;
   logic [2:0]    key_oct_reg [NUM_KEYS];
   logic [2:0]    octave_reg;
   logic [1:0]    oct_held_reg;

   key_map_t    map;
   logic        is_note;
   logic        make_note;
   logic        push;
   note_event_t push_ev;
   note_event_t head_ev;
   logic        fifo_empty;

   assign map       = map_code(scan_code);
   assign is_note   = map.hit && (map.key < 4'(NUM_KEYS));
   assign make_note = scan_valid && (state_reg == ST_IDLE) && is_note && !held_reg[map.key];

   always_comb begin
      push    = 1'b0;
      push_ev = '0;
      if (make_note) begin
         push    = 1'b1;
         push_ev = '{on: 1'b1, note: note_number(octave_reg, map.key)};
      end else if (scan_valid && (state_reg == ST_BREAK) && is_note && held_reg[map.key]) begin
         push    = 1'b1;
         push_ev = '{on: 1'b0, note: note_number(key_oct_reg[map.key], map.key)};
      end
   end

   always_ff @(posedge clock50 or negedge reset_n) begin
      if (!reset_n) begin
         state_reg    <= ST_IDLE;
         held_reg     <= '0;
         octave_reg   <= 3'(OCT_RESET);
         oct_held_reg <= '0;
      end else if (scan_valid) begin
         case (state_reg)
            ST_IDLE: begin
               if (scan_code == SC_BREAK) begin
                  state_reg <= ST_BREAK;
               end else if (scan_code == SC_EXT) begin
                  state_reg <= ST_EXT;
               end else if (make_note) begin
                  held_reg[map.key] <= 1'b1;
               end else if (map.hit && map.key == KEY_OCT_DOWN && !oct_held_reg[0]) begin
                  oct_held_reg[0] <= 1'b1;
                  if (octave_reg != 3'd0) octave_reg <= octave_reg - 3'd1;
               end else if (map.hit && map.key == KEY_OCT_UP && !oct_held_reg[1]) begin
                  oct_held_reg[1] <= 1'b1;
                  if (octave_reg != 3'd7) octave_reg <= octave_reg + 3'd1;
               end
            end
            ST_BREAK: begin
               state_reg <= ST_IDLE;
               if (is_note) held_reg[map.key] <= 1'b0;
               if (map.hit && map.key == KEY_OCT_DOWN) oct_held_reg[0] <= 1'b0;
               if (map.hit && map.key == KEY_OCT_UP)   oct_held_reg[1] <= 1'b0;
            end
            ST_EXT:  state_reg <= (scan_code == SC_BREAK) ? ST_EXT_BREAK : ST_IDLE;
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   // Octave captured at press so the release reports the same note number
   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key_oct
      always_ff @(posedge clock50 or negedge reset_n) begin
         if (!reset_n) begin
            key_oct_reg[gi] <= 3'd0;
         end else if (make_note && map.key == 4'(gi)) begin
            key_oct_reg[gi] <= octave_reg;
         end
      end
   end

   event_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clock50),
      .rst_n     (reset_n),
      .push      (push),
      .push_data (push_ev),
      .pop       (ev.ev_ready),
      .head_data (head_ev),
      .empty     (fifo_empty),
      .overflow  (overflow)
   );

   assign ev.ev_valid = !fifo_empty;
   assign ev.ev_on    = head_ev.on;
   assign ev.ev_note  = head_ev.note;
   assign held        = held_reg;
   assign octave      = octave_reg;
endmodule

// File: tb/tb_ps2_note_decoder.sv
// Bench for ps2_note_decoder: directed scenarios plus random byte streams,
// checked against a queue-based model of the key/octave/event rules.
module tb_ps2_note_decoder;
   localparam int DEPTH = 4;

   logic        clock50 = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  scan_code = 8'h00;
   logic        scan_valid = 1'b0;
   logic [12:0] held;
   logic [2:0]  octave;
   logic        overflow;

   ps2_note_decoder_if evif();

   always #10 clock50 = ~clock50;

   ps2_note_decoder #(.FIFO_DEPTH(DEPTH), .OCT_RESET(4)) dut (
      .clock50    (clock50),
      .reset_n    (reset_n),
      .scan_code  (scan_code),
      .scan_valid (scan_valid),
      .ev         (evif.master),
      .held       (held),
      .octave     (octave),
      .overflow   (overflow)
   );

   int vectors = 0;
   int miscompares = 0;

   bit [7:0]  note_codes [13] = '{8'h1C, 8'h1D, 8'h1B, 8'h24, 8'h23, 8'h2B, 8'h2C,
                                  8'h34, 8'h35, 8'h33, 8'h3C, 8'h3B, 8'h42};
   bit [7:0]  exp_q[$];
   bit [7:0]  obs_q[$];
   bit [7:0]  m_fifo[$];
   bit [7:0]  m_pfx[$];
   bit [12:0] m_held;
   int        m_koct [13];
   int        m_oct;
   bit [1:0]  m_octheld;
   bit        m_ovf;

   function automatic int key_of(input bit [7:0] c);
      for (int i = 0; i < 13; i++) if (note_codes[i] == c) return i;
      return -1;
   endfunction

   function automatic bit [6:0] note_of(input int o, input int k);
      int n;
      n = 12 * o + k;
      if (n > 95) n = 95;
      return 7'(n);
   endfunction

   function automatic void model_reset();
      m_fifo.delete();
      m_pfx.delete();
      exp_q.delete();
      obs_q.delete();
      m_held = '0;
      foreach (m_koct[i]) m_koct[i] = 0;
      m_oct = 4;
      m_octheld = '0;
      m_ovf = 1'b0;
   endfunction

   // One received byte: returns the event it produces, if any
   function automatic void model_byte(input bit [7:0] c, output bit has, output bit [7:0] ev);
      int k;
      has = 1'b0;
      ev = '0;
      k = key_of(c);
      if (m_pfx.size() == 0) begin
         if (c == 8'hF0 || c == 8'hE0) begin
            m_pfx.push_back(c);
         end else if (k >= 0) begin
            if (!m_held[k]) begin
               m_held[k] = 1'b1;
               m_koct[k] = m_oct;
               has = 1'b1;
               ev = {1'b1, note_of(m_oct, k)};
            end
         end else if (c == 8'h1A && !m_octheld[0]) begin
            m_octheld[0] = 1'b1;
            if (m_oct > 0) m_oct--;
         end else if (c == 8'h22 && !m_octheld[1]) begin
            m_octheld[1] = 1'b1;
            if (m_oct < 7) m_oct++;
         end
      end else if (m_pfx[0] == 8'hF0) begin
         m_pfx.delete();
         if (k >= 0 && m_held[k]) begin
            m_held[k] = 1'b0;
            has = 1'b1;
            ev = {1'b0, note_of(m_koct[k], k)};
         end else if (c == 8'h1A) begin
            m_octheld[0] = 1'b0;
         end else if (c == 8'h22) begin
            m_octheld[1] = 1'b0;
         end
      end else if (m_pfx.size() == 1 && c == 8'hF0) begin
         m_pfx.push_back(c);
      end else begin
         m_pfx.delete();
      end
   endfunction

   function automatic int queue_diff();
      int d;
      d = (exp_q.size() == obs_q.size()) ? 0 : 1;
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
         if (exp_q[i] !== obs_q[i]) d++;
      return d;
   endfunction

   // One clock: drive at the falling edge, record a DUT pop, advance the model
   task automatic step(input bit v, input bit [7:0] c, input bit r);
      bit full_b, m_pop, has;
      bit [7:0] ev;
      scan_valid = v;
      scan_code  = c;
      evif.ev_ready = r;
      if (evif.ev_valid === 1'b1 && r) obs_q.push_back({evif.ev_on, evif.ev_note});
      full_b = (m_fifo.size() == DEPTH);
      m_pop  = r && (m_fifo.size() != 0);
      if (m_pop) exp_q.push_back(m_fifo.pop_front());
      if (v) begin
         model_byte(c, has, ev);
         if (has) begin
            if (!full_b || m_pop) m_fifo.push_back(ev);
            else m_ovf = 1'b1;
         end
      end
      @(posedge clock50);
      @(negedge clock50);
      scan_valid = 1'b0;
   endtask

   task automatic drain();
      repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1);
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      scan_valid = 1'b0;
      evif.ev_ready = 1'b0;
      model_reset();
      repeat (2) @(negedge clock50);
   endtask

   task automatic test_reset();
      apply_reset();
      vectors++; if (evif.ev_valid !== 1'b0) begin miscompares++; $display("FAIL reset_ev_valid: got %b want 0", evif.ev_valid); end
      vectors++; if (evif.ev_on !== 1'b0) begin miscompares++; $display("FAIL reset_ev_on: got %b want 0", evif.ev_on); end
      vectors++; if (evif.ev_note !== 7'd0) begin miscompares++; $display("FAIL reset_ev_note: got %0d want 0", evif.ev_note); end
      vectors++; if (held !== 13'd0) begin miscompares++; $display("FAIL reset_held: got %h want 0", held); end
      vectors++; if (octave !== 3'd4) begin miscompares++; $display("FAIL reset_octave: got %0d want 4", octave); end
      vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
      reset_n = 1'b1;
      @(negedge clock50);
   endtask

   task automatic test_press_release();
      exp_q.delete(); obs_q.delete();
      step(1'b1, 8'h1C, 1'b1);
      vectors++; if (held[0] !== 1'b1) begin miscompares++; $display("FAIL press_held0: got %b want 1", held[0]); end
      step(1'b1, 8'hF0, 1'b1);
      step(1'b1, 8'h1C, 1'b1);
      vectors++; if (held[0] !== 1'b0) begin miscompares++; $display("FAIL release_held0: got %b want 0", held[0]); end
      drain();
      vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL press_count: got %0d want 2", obs_q.size()); end
      vectors++; if (obs_q[0] !== 8'hB0) begin miscompares++; $display("FAIL press_on48: got %h want b0", obs_q[0]); end
      vectors++; if (obs_q[1] !== 8'h30) begin miscompares++; $display("FAIL press_off48: got %h want 30", obs_q[1]); end
      vectors++; if (queue_diff() != 0) begin miscompares++; $display("FAIL press_model: got %0d events want %0d", obs_q.size(), exp_q.size()); end
   endtask

   task automatic test_typematic();
      exp_q.delete(); obs_q.delete();
      repeat (3) step(1'b1, 8'h1D, 1'b1);
      step(1'b1, 8'hF0, 1'b1);
      step(1'b1, 8'h1D, 1'b1);
      drain();
      vectors++; if (obs_q.size() != 2) begin miscompares++; $display("FAIL typematic_count: got %0d want 2", obs_q.size()); end
      vectors++; if (obs_q[0] !== 8'hB1) begin miscompares++; $display("FAIL typematic_on49: got %h want b1", obs_q[0]); end
      vectors++; if (obs_q[1] !== 8'h31) begin miscompares++; $display("FAIL typematic_off49: got %h want 31", obs_q[1]); end
   endtask

   task automatic test_octave_latch();
      exp_q.delete(); obs_q.delete();
      step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'h22, 1'b1);
      vectors++; if (octave !== 3'd5) begin miscompares++; $display("FAIL latch_octave: got %0d want 5", octave); end
      step(1'b1, 8'hF0, 1'b1);
      step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'h1C, 1'b1);
      drain();
      vectors++; if (obs_q.size() != 3) begin miscompares++; $display("FAIL latch_count: got %0d want 3", obs_q.size()); end
      vectors++; if (obs_q[1] !== 8'h30) begin miscompares++; $display("FAIL latch_off48: got %h want 30", obs_q[1]); end
      vectors++; if (obs_q[2] !== 8'hBC) begin miscompares++; $display("FAIL latch_on60: got %h want bc", obs_q[2]); end
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h22, 1'b1);
      drain();
   endtask

   task automatic test_octave_saturation();
      repeat (8) begin
         step(1'b1, 8'h1A, 1'b1); step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1A, 1'b1);
      end
      vectors++; if (octave !== 3'd0) begin miscompares++; $display("FAIL sat_low_octave: got %0d want 0", octave); end
      exp_q.delete(); obs_q.delete();
      step(1'b1, 8'h42, 1'b1);
      drain();
      vectors++; if (obs_q[0] !== 8'h8C) begin miscompares++; $display("FAIL sat_low_on12: got %h want 8c", obs_q[0]); end
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h42, 1'b1);
      repeat (8) begin
         step(1'b1, 8'h22, 1'b1); step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h22, 1'b1);
      end
      vectors++; if (octave !== 3'd7) begin miscompares++; $display("FAIL sat_high_octave: got %0d want 7", octave); end
      exp_q.delete(); obs_q.delete();
      step(1'b1, 8'h42, 1'b1);
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h42, 1'b1);
      drain();
      vectors++; if (obs_q[0] !== 8'hDF) begin miscompares++; $display("FAIL sat_high_on95: got %h want df", obs_q[0]); end
      vectors++; if (obs_q[1] !== 8'h5F) begin miscompares++; $display("FAIL sat_high_off95: got %h want 5f", obs_q[1]); end
   endtask

   task automatic test_ext_unmapped();
      exp_q.delete(); obs_q.delete();
      step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'hE0, 1'b1); step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1C, 1'b1);
      step(1'b1, 8'hAA, 1'b1); step(1'b1, 8'h15, 1'b1);
      drain();
      vectors++; if (obs_q.size() != 0) begin miscompares++; $display("FAIL ext_no_events: got %0d want 0", obs_q.size()); end
      vectors++; if (held !== 13'd0) begin miscompares++; $display("FAIL ext_held: got %h want 0", held); end
      step(1'b1, 8'h1C, 1'b1);
      drain();
      vectors++; if (obs_q[0] !== 8'hD4) begin miscompares++; $display("FAIL ext_idle_on84: got %h want d4", obs_q[0]); end
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1C, 1'b1);
      drain();
   endtask

   task automatic test_overflow();
      exp_q.delete(); obs_q.delete();
      for (int i = 0; i < 5; i++) step(1'b1, note_codes[i], 1'b0);
      step(1'b0, 8'h00, 1'b0);
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_flag: got %b want 1", overflow); end
      vectors++; if (held !== 13'h001F) begin miscompares++; $display("FAIL ovf_held: got %h want 001f", held); end
      vectors++; if (evif.ev_on !== 1'b1 || evif.ev_note !== 7'd84) begin miscompares++; $display("FAIL ovf_head_stable: got %b/%0d want 1/84", evif.ev_on, evif.ev_note); end
      drain();
      vectors++; if (obs_q.size() != 4) begin miscompares++; $display("FAIL ovf_count: got %0d want 4", obs_q.size()); end
      for (int i = 0; i < 4; i++) begin
         vectors++; if (obs_q[i] !== 8'(8'hD4 + i)) begin miscompares++; $display("FAIL ovf_order%0d: got %h want %h", i, obs_q[i], 8'(8'hD4 + i)); end
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'hF0, 1'b1); step(1'b1, note_codes[i], 1'b1);
      end
      drain();
      vectors++; if (queue_diff() != 0) begin miscompares++; $display("FAIL ovf_model: got %0d events want %0d", obs_q.size(), exp_q.size()); end
      vectors++; if (overflow !== 1'b1) begin miscompares++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
      // Reset right after a break prefix must forget the prefix and the queue
      step(1'b1, 8'h1D, 1'b0);
      step(1'b1, 8'hF0, 1'b0);
      apply_reset();
      vectors++; if (evif.ev_valid !== 1'b0) begin miscompares++; $display("FAIL midreset_valid: got %b want 0", evif.ev_valid); end
      vectors++; if (held !== 13'd0 || overflow !== 1'b0 || octave !== 3'd4) begin miscompares++; $display("FAIL midreset_state: got %h/%b/%0d want 0/0/4", held, overflow, octave); end
      reset_n = 1'b1;
      @(negedge clock50);
      step(1'b1, 8'h1C, 1'b1);
      drain();
      vectors++; if (obs_q.size() != 1 || obs_q[0] !== 8'hB0) begin miscompares++; $display("FAIL midreset_make: got %0d events first %h want 1 b0", obs_q.size(), obs_q[0]); end
      step(1'b1, 8'hF0, 1'b1); step(1'b1, 8'h1C, 1'b1);
      drain();
   endtask

   task automatic test_back_to_back();
      bit [7:0] seq [9] = '{8'h1C, 8'h1D, 8'hF0, 8'h1C, 8'hF0, 8'h1D, 8'h1B, 8'hF0, 8'h1B};
      exp_q.delete(); obs_q.delete();
      foreach (seq[i]) step(1'b1, seq[i], 1'b1);
      drain();
      vectors++; if (obs_q.size() != 6) begin miscompares++; $display("FAIL b2b_count: got %0d want 6", obs_q.size()); end
      vectors++; if (queue_diff() != 0) begin miscompares++; $display("FAIL b2b_model: %0d differing entries", queue_diff()); end
   endtask

   task automatic test_random();
      bit [7:0] c;
      int sel;
      exp_q.delete(); obs_q.delete();
      for (int n = 1; n <= 600; n++) begin
         sel = $urandom_range(0, 99);
         if (sel < 45)      c = note_codes[$urandom_range(0, 12)];
         else if (sel < 60) c = 8'hF0;
         else if (sel < 65) c = 8'hE0;
         else if (sel < 75) c = ($urandom_range(0, 1) != 0) ? 8'h1A : 8'h22;
         else               c = 8'($urandom);
         step($urandom_range(0, 3) != 0, c, $urandom_range(0, 2) != 0);
         if (n % 100 == 0) begin
            vectors++; if (held !== m_held) begin miscompares++; $display("FAIL rand_held@%0d: got %h want %h", n, held, m_held); end
            vectors++; if (octave !== 3'(m_oct)) begin miscompares++; $display("FAIL rand_octave@%0d: got %0d want %0d", n, octave, m_oct); end
            vectors++; if (overflow !== m_ovf) begin miscompares++; $display("FAIL rand_overflow@%0d: got %b want %b", n, overflow, m_ovf); end
            vectors++; if (evif.ev_valid !== (m_fifo.size() != 0)) begin miscompares++; $display("FAIL rand_valid@%0d: got %b want %b", n, evif.ev_valid, m_fifo.size() != 0); end
         end
      end
      drain();
      vectors++; if (queue_diff() != 0) begin miscompares++; $display("FAIL rand_events: got %0d events want %0d, %0d differ", obs_q.size(), exp_q.size(), queue_diff()); end
   endtask

   initial begin
      test_reset();
      test_press_release();
      test_typematic();
      test_octave_latch();
      test_octave_saturation();
      test_ext_unmapped();
      test_overflow();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
